// File: rtl/calib_offset_seq.sv
// ADC offset-calibration sequencer: settle, average 2^N samples per channel,
// negate and saturate the averages, then strobe them into the offset registers.
module calib_offset_seq #(
  parameter int DWA  = 14,
  parameter int DWS  = 14,
  parameter int LMAX = 12,
  parameter int SWS  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ctl_start,
  input  logic                  ctl_abort,
  input  logic [SWS-1:0]        cfg_settle,
  input  logic [3:0]            cfg_log2n,
  input  logic signed [DWA-1:0] adc_dat [2],
  input  logic                  adc_vld,
  output logic signed [DWS-1:0] cal_sum [2],
  output logic                  cal_wen,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic                  sts_sat
);

  typedef enum logic [2:0] {IDLE, SETTLE, ACC, CALC, DONE} state_t;

  localparam int AW = DWA + LMAX;
  localparam int CW = LMAX + 1;
  // Wide enough for -avg (DWA+1 bits) and both DWS saturation limits.
  localparam int WW = DWA + DWS + 2;
  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-DWS+1){1'b0}}, {(DWS-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW-DWS+1){1'b1}}, {(DWS-1){1'b0}}};
  localparam logic [3:0]           LOG2N_MAX = 4'(LMAX);

  state_t                state, state_nxt;
  logic [SWS-1:0]        settle_len, settle_cnt;
  logic [3:0]            log2n, log2n_clamp;
  logic [CW-1:0]         smp_cnt, smp_target;
  logic signed [AW-1:0]  acc [2];
  logic signed [WW-1:0]  neg [2];
  logic signed [DWS-1:0] off [2];
  logic                  sat_any;
  logic                  start_ok, abort_run, settle_end, last_smp;

  assign abort_run   = ctl_abort && (state != IDLE);
  assign start_ok    = (state == IDLE) && ctl_start && !ctl_abort;
  assign log2n_clamp = (cfg_log2n > LOG2N_MAX) ? LOG2N_MAX : cfg_log2n;
  assign smp_target  = CW'(1) << log2n;
  assign settle_end  = (settle_cnt == settle_len - SWS'(1));
  assign last_smp    = adc_vld && (smp_cnt + CW'(1) == smp_target);

  assign cal_wen  = (state == DONE);
  assign sts_busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = (cfg_settle == '0) ? ACC : SETTLE;
      SETTLE:  if (settle_end) state_nxt = ACC;
      ACC:     if (last_smp) state_nxt = CALC;
      CALC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_run) state_nxt = IDLE;
  end

  // Floor average via arithmetic shift, negate at full width, clamp to DWS.
  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < 2; i++) begin
      neg[i] = -WW'(DWA'(acc[i] >>> log2n));
      off[i] = neg[i][DWS-1:0];
      if (neg[i] > SAT_MAX) begin
        off[i]  = SAT_MAX[DWS-1:0];
        sat_any = 1'b1;
      end else if (neg[i] < SAT_MIN) begin
        off[i]  = SAT_MIN[DWS-1:0];
        sat_any = 1'b1;
      end
    end
  end

  // NOTE: the accumulator pair is plain flops, not a RAM, so it takes the
  // asynchronous reset like every other register here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      settle_len <= '0;
      settle_cnt <= '0;
      log2n      <= '0;
      smp_cnt    <= '0;
      sts_done   <= 1'b0;
      sts_sat    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        acc[i]     <= '0;
        cal_sum[i] <= '0;
      end
    end else if (abort_run) begin
      settle_cnt <= '0;
      smp_cnt    <= '0;
      for (int i = 0; i < 2; i++) acc[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            settle_len <= cfg_settle;
            log2n      <= log2n_clamp;
            settle_cnt <= '0;
            smp_cnt    <= '0;
            sts_done   <= 1'b0;
            sts_sat    <= 1'b0;
            for (int i = 0; i < 2; i++) acc[i] <= '0;
          end
        end
        SETTLE: settle_cnt <= settle_cnt + SWS'(1);
        ACC: begin
          if (adc_vld) begin
            smp_cnt <= smp_cnt + CW'(1);
            for (int i = 0; i < 2; i++) acc[i] <= acc[i] + AW'(adc_dat[i]);
          end
        end
        // Results land at the edge entering DONE so they are valid with cal_wen.
        CALC: begin
          sts_done <= 1'b1;
          if (sat_any) sts_sat <= 1'b1;
          for (int i = 0; i < 2; i++) cal_sum[i] <= off[i];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/calib_offset_seq.md
# calib_offset_seq

Automatic ADC offset-calibration sequencer for the two-channel acquisition path.
- On a start request it waits a settling interval, then averages 2^N valid samples per channel with the inputs shorted or terminated.
- It negates the averages, saturates them to the offset-register width, and issues a one-cycle write strobe.
- The strobe loads the results into the ADC offset (summation) calibration registers.
- It sits between the system-bus control registers (start/abort/config/status) and the calibration register block.

## Interface
Parameters:
- DWA, 14, ADC sample width (signed)
- DWS, 14, calibration offset width (signed)
- LMAX, 12, maximum log2 of sample count; accumulator width is DWA+LMAX
- SWS, 16, settle counter width

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous assert, active-low
- ctl_start  in  1  start pulse; honoured only in IDLE
- ctl_abort  in  1  abort; has priority over start and all state transitions
- cfg_settle  in  SWS  settle length in clk cycles
- cfg_log2n  in  4  log2 of samples per channel; values above LMAX are clamped to LMAX
- adc_dat  in  [2][DWA] signed  channel 0/1 samples
- adc_vld  in  1  sample qualifier, common to both channels
- cal_sum  out  [2][DWS] signed  computed offsets
- cal_wen  out  1  one-cycle write strobe for cal_sum
- sts_busy  out  1  high in any state other than IDLE
- sts_done  out  1  sticky; set with cal_wen, cleared by accepted start
- sts_sat  out  1  sticky; set if either channel saturated, cleared by accepted start

## Operation
- Reset values: cal_sum = 0/0, cal_wen = 0, sts_busy = 0, sts_done = 0, sts_sat = 0, state = IDLE, counters and accumulators = 0.
- States and transitions:
  - IDLE: on ctl_start, latch cfg_settle and clamped cfg_log2n, clear accumulators, sts_done and sts_sat. Go to SETTLE, or to ACC if cfg_settle == 0.
  - SETTLE: count clk cycles; leave after exactly cfg_settle cycles in SETTLE → ACC. adc_vld is ignored.
  - ACC: on each adc_vld, add sign-extended adc_dat[i] to acc[i] and increment the sample counter. When the counter reaches 2^log2n (that sample included) → CALC.
  - CALC (1 cycle): avg[i] = acc[i] >>> log2n (arithmetic, floor); off[i] = -avg[i], computed at DWA+1 bits. Saturate to [-2^(DWS-1), 2^(DWS-1)-1]; on saturation of either channel set sts_sat. → DONE.
  - DONE (1 cycle): cal_sum ← off, cal_wen = 1, sts_done ← 1. → IDLE.
- Abort: in any non-IDLE state, next state is IDLE. No cal_wen is issued, cal_sum and sts_done keep their previous values, and accumulators are cleared. Abort in IDLE has no effect. Abort and start in the same IDLE cycle: start is ignored.
- ctl_start outside IDLE is ignored (no restart, no status change).
- Configuration inputs changing mid-run have no effect; the values latched at start are used.
- adc_vld during CALC/DONE/IDLE is ignored.
- The accumulator cannot overflow: 2^LMAX samples of DWA bits fit in DWA+LMAX bits.
- Width rule for DWS < DWA: saturation uses the DWS range. For DWS ≥ DWA, values are sign-extended and only -avg = +2^(DWA-1) can need saturation, which happens only when DWS == DWA.

## Timing
- Start sampled at cycle T (IDLE): sts_busy = 1 from T+1.
- cfg_settle = S > 0: first adc_vld accepted at T+1+S. With adc_vld constantly high, the last sample is at T+S+2^N.
- CALC is at T+S+2^N+1 and DONE (cal_wen high, cal_sum valid) at T+S+2^N+2. sts_busy falls at T+S+2^N+3.
- S = 0: ACC starts at T+1; cal_wen at T+2^N+2.
- cal_wen is high for exactly one cycle per completed run. cal_sum changes only in the cal_wen cycle.
- Abort sampled at cycle A: state = IDLE, sts_busy = 0 at A+1.
- Asynchronous reset mid-run: all outputs take reset values immediately. The first start after release behaves as from power-up.

## Test plan
- Basic: S=4, N=3, adc_dat = {+100, -37} constant, adc_vld=1 → cal_wen one cycle at T+14, cal_sum = {-100, +37}, sts_done=1, sts_sat=0.
- Floor rounding and gaps: N=2, ch0 samples 1,2,2,2 (sum 7) with adc_vld toggling 1/0 → avg 1, cal_sum[0] = -1. Ch1 samples -1,-2,-2,-2 (sum -7) → avg -2, cal_sum[1] = +2. Exactly 4 qualified samples consumed.
- Saturation (DWS=DWA=14): adc_dat[0] = -8192 constant, N=0 → cal_sum[0] = +8191, sts_sat=1. Next start clears sts_sat.
- Abort: start, assert ctl_abort during ACC after 3 of 8 samples → IDLE next cycle, no cal_wen, cal_sum unchanged from the prior run, sts_busy=0.
- Start ignored while busy, plus clamp: second ctl_start pulses during SETTLE leave timing unchanged. cfg_log2n=15 with LMAX=12 runs exactly 4096 samples.
- Reset: assert rstn low during ACC → all outputs 0 immediately. After release, a run with S=0, N=1, inputs {5,5} gives cal_sum = {-5, -5} at T+4.
